sym_tuple_decoder_pipe: RTL and testbench

Pipelined, parametrised tuple decoder. Each input word holds N_SYM symbols of SYM_W bits. Every symbol is matched against a programmable dictionary of N_CODES entries, and the resulting codes are packed into a 1-based tuple index (0 = miss). It sits on a valid/ready stream and keeps saturating hit/miss statistics.

---
 rtl/sym_tuple_decoder_pipe.sv | 194 +++++++++++++++++++
 tb/tb_sym_tuple_decoder_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_tuple_decoder_pipe.sv
// ---------------------------------------------------------------------------
// sym_tuple_decoder_pipe
//
// Purpose
//   Two-stage pipelined tuple decoder. Each input beat carries N_SYM symbols
//   of SYM_W bits, with symbol 0 in the most-significant slice. Every symbol
//   is looked up in a small programmable dictionary of N_CODES entries. The
//   per-symbol codes are then packed into a 1-based tuple index, which is 0
//   when any symbol misses. Output transfers are counted into saturating hit
//   and miss counters.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input stream handshake
//   in_data              N_SYM symbols, symbol 0 in the MS slice
//   out_valid/out_ready  output stream handshake
//   out_index            1 + packed codes, or 0 on a miss
//   out_hit              all symbols matched
//   tbl_we/addr/data/inv dictionary write or invalidate
//   cnt_clr              synchronous clear of both counters
//   hit_cnt/miss_cnt     saturating transfer counters
//
// Handshake: a beat moves when valid && ready are both high at a rising
// edge. in_ready is combinational from pipeline occupancy and out_ready.
// It never depends on in_valid. While out_valid && !out_ready, out_index
// and out_hit hold their values.
// ---------------------------------------------------------------------------
module sym_tuple_decoder_pipe #(
  parameter int SYM_W   = 32,
  parameter int N_SYM   = 4,
  parameter int N_CODES = 4,
  parameter int CNT_W   = 16,
  localparam int CODE_W = $clog2(N_CODES),
  localparam int OUT_W  = N_SYM * CODE_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_SYM*SYM_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_index,
  output logic                     out_hit,
  input  logic                     tbl_we,
  input  logic [CODE_W-1:0]        tbl_addr,
  input  logic [SYM_W-1:0]         tbl_data,
  input  logic                     tbl_inv,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);

  // Power-on dictionary contents. Entries beyond the fourth have no default
  // value and start out invalid.
  function automatic logic [SYM_W-1:0] dflt_entry(input int j);
    logic [31:0] v;
    case (j)
      0:       v = 32'hDEADBEEF;
      1:       v = 32'h0BAD0B01;
      2:       v = 32'hC001D00D;
      3:       v = 32'h12345678;
      default: v = 32'h0;
    endcase
    return SYM_W'(v);
  endfunction

  // ------------------------------------------------------------------------
  // Dictionary
  // ------------------------------------------------------------------------
  logic [SYM_W-1:0]   tbl_val [N_CODES];
  logic [N_CODES-1:0] tbl_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_CODES; j++) begin
        tbl_val[j] <= dflt_entry(j);
        tbl_vld[j] <= (j < 4);
      end
    end else if (tbl_we) begin
      if (tbl_inv) begin
        tbl_vld[tbl_addr] <= 1'b0;
      end else begin
        tbl_val[tbl_addr] <= tbl_data;
        tbl_vld[tbl_addr] <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------------
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // ------------------------------------------------------------------------
  // Stage 1: per-symbol lookup against the registered dictionary.
  // A table write in the accepting cycle therefore does not affect the
  // beat being accepted.
  // ------------------------------------------------------------------------
  logic [CODE_W-1:0] lk_code [N_SYM];
  logic [N_SYM-1:0]  lk_hit;

  // The loop scans from the top entry down, so the last match assigned is
  // the lowest-numbered one. That makes duplicate values resolve to the
  // lowest index.
  always_comb begin
    for (int i = 0; i < N_SYM; i++) begin
      lk_code[i] = '0;
      lk_hit[i]  = 1'b0;
      for (int j = N_CODES - 1; j >= 0; j--) begin
        if (tbl_vld[j] && (tbl_val[j] == in_data[(N_SYM-1-i)*SYM_W +: SYM_W])) begin
          lk_code[i] = CODE_W'(j);
          lk_hit[i]  = 1'b1;
        end
      end
    end
  end

  logic [CODE_W-1:0] s1_code [N_SYM];
  logic [N_SYM-1:0]  s1_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      for (int i = 0; i < N_SYM; i++) s1_code[i] <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= lk_code;
        s1_hit  <= lk_hit;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stage 2: pack the codes into the tuple index.
  // The sum of code_i * N_CODES^(N_SYM-1-i) equals the codes concatenated
  // with symbol 0 in the MS position, because N_CODES is a power of two.
  // Its maximum is N_CODES^N_SYM - 1, so adding 1 fits in OUT_W bits.
  // ------------------------------------------------------------------------
  logic [N_SYM*CODE_W-1:0] s1_packed;
  logic                    s2_hit;
  logic [OUT_W-1:0]        s2_index;

  always_comb begin
    s1_packed = '0;
    for (int i = 0; i < N_SYM; i++) begin
      s1_packed[(N_SYM-1-i)*CODE_W +: CODE_W] = s1_code[i];
    end
    s2_hit   = &s1_hit;
    s2_index = s2_hit ? ({1'b0, s1_packed} + OUT_W'(1)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_hit   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_index <= s2_index;
        out_hit   <= s2_hit;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Statistics. A clear takes priority over an increment in the same cycle.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sym_tuple_decoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_sym_tuple_decoder_pipe
//
// Self-checking bench for sym_tuple_decoder_pipe. Two instances share all
// inputs: one uses 16-bit counters, the other uses 4-bit counters so that
// saturation is reachable. A negedge monitor keeps a transaction-level model:
//   - a dictionary array,
//   - a queue of expected indices with their age in cycles,
//   - plain integer counters.
// Every cycle it compares both instances against this model.
// ---------------------------------------------------------------------------
module tb_sym_tuple_decoder_pipe;

  localparam int SYM_W   = 32;
  localparam int N_SYM   = 4;
  localparam int N_CODES = 4;
  localparam int CODE_W  = $clog2(N_CODES);
  localparam int OUT_W   = N_SYM * CODE_W + 1;
  localparam int DW      = N_SYM * SYM_W;

  localparam logic [31:0] SA = 32'hDEADBEEF;
  localparam logic [31:0] SB = 32'h0BAD0B01;
  localparam logic [31:0] SC = 32'hC001D00D;
  localparam logic [31:0] SD = 32'h12345678;
  localparam logic [31:0] SF = 32'hCAFEF00D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic              in_valid, out_ready, tbl_we, tbl_inv, cnt_clr;
  logic [DW-1:0]     in_data;
  logic [CODE_W-1:0] tbl_addr;
  logic [SYM_W-1:0]  tbl_data;

  logic              in_ready, out_valid, out_hit;
  logic [OUT_W-1:0]  out_index;
  logic [15:0]       hit_cnt, miss_cnt;

  logic              in_ready4, out_valid4, out_hit4;
  logic [OUT_W-1:0]  out_index4;
  logic [3:0]        hit_cnt4, miss_cnt4;

  sym_tuple_decoder_pipe #(.SYM_W(SYM_W), .N_SYM(N_SYM), .N_CODES(N_CODES), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_hit(out_hit),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_inv(tbl_inv),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  sym_tuple_decoder_pipe #(.SYM_W(SYM_W), .N_SYM(N_SYM), .N_CODES(N_CODES), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_index(out_index4), .out_hit(out_hit4),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_inv(tbl_inv),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [SYM_W-1:0]  m_val [N_CODES];
  bit                m_vld [N_CODES];
  logic [OUT_W-1:0]  exp_q [$];
  int                age_q [$];
  int                m_hit16, m_miss16, m_hit4, m_miss4;

  task automatic model_reset();
    for (int j = 0; j < N_CODES; j++) begin
      case (j)
        0: m_val[j] = SA;
        1: m_val[j] = SB;
        2: m_val[j] = SC;
        3: m_val[j] = SD;
        default: m_val[j] = '0;
      endcase
      m_vld[j] = (j < 4);
    end
    exp_q.delete();
    age_q.delete();
    m_hit16 = 0; m_miss16 = 0; m_hit4 = 0; m_miss4 = 0;
  endtask

  // Index = 1 + sum code_i * N_CODES^(N_SYM-1-i). A miss yields 0.
  // Each symbol takes the first valid dictionary entry that matches it.
  function automatic logic [OUT_W-1:0] ref_index(input logic [DW-1:0] d);
    int idx = 0;
    bit all_hit = 1;
    for (int i = 0; i < N_SYM; i++) begin
      logic [SYM_W-1:0] s;
      int code;
      s = d[(N_SYM-1-i)*SYM_W +: SYM_W];
      code = -1;
      for (int j = 0; j < N_CODES; j++)
        if (code < 0 && m_vld[j] && m_val[j] == s) code = j;
      if (code < 0) all_hit = 0;
      else idx += code * (N_CODES ** (N_SYM - 1 - i));
    end
    return all_hit ? OUT_W'(idx + 1) : '0;
  endfunction

  // Monitor. Inputs change only just after posedge, so the values seen at
  // negedge are the ones the next posedge acts on. The monitor first checks
  // the current outputs, then applies that coming edge to the model.
  always @(negedge clk) begin
    bit vis, rdy, xfer;
    logic [OUT_W-1:0] e;
    if (!rst_n) begin
      model_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_out_hit",   out_hit, 0);
      chk("rst_hit_cnt",   hit_cnt, 0);
      chk("rst_miss_cnt",  miss_cnt, 0);
      chk("rst_in_ready",  in_ready, 1);
    end else begin
      // The oldest beat is presented once it has been in flight for 2 edges.
      // At most two beats can be held, and a third is accepted only while
      // the output drains.
      vis  = (exp_q.size() > 0) && (age_q[0] >= 2);
      rdy  = (exp_q.size() < 2) || out_ready;
      xfer = vis && out_ready;
      e    = vis ? exp_q[0] : '0;
      chk("out_valid",  out_valid,  vis);
      chk("out_valid4", out_valid4, vis);
      chk("in_ready",   in_ready,   rdy);
      chk("in_ready4",  in_ready4,  rdy);
      if (vis) begin
        chk("out_index",  out_index,  e);
        chk("out_hit",    out_hit,    e != 0);
        chk("out_index4", out_index4, e);
        chk("out_hit4",   out_hit4,   e != 0);
      end
      chk("hit_cnt",   hit_cnt,   m_hit16);
      chk("miss_cnt",  miss_cnt,  m_miss16);
      chk("hit_cnt4",  hit_cnt4,  m_hit4);
      chk("miss_cnt4", miss_cnt4, m_miss4);
      if (cnt_clr) begin
        m_hit16 = 0; m_miss16 = 0; m_hit4 = 0; m_miss4 = 0;
      end else if (xfer) begin
        if (e != 0) begin
          if (m_hit16 < 65535) m_hit16++;
          if (m_hit4 < 15) m_hit4++;
        end else begin
          if (m_miss16 < 65535) m_miss16++;
          if (m_miss4 < 15) m_miss4++;
        end
      end
      if (xfer) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      if (in_valid && rdy) begin
        exp_q.push_back(ref_index(in_data));
        age_q.push_back(0);
      end
      foreach (age_q[k]) age_q[k]++;
      // The lookup above used the old dictionary; this write affects later beats.
      if (tbl_we) begin
        if (tbl_inv) m_vld[tbl_addr] = 0;
        else begin
          m_val[tbl_addr] = tbl_data;
          m_vld[tbl_addr] = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] tup(input logic [31:0] s0, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] s3);
    return {s0, s1, s2, s3};
  endfunction

  function automatic logic [31:0] dict_sym(input int k);
    case (k)
      0: return SA;
      1: return SB;
      2: return SC;
      default: return SD;
    endcase
  endfunction

  function automatic logic [31:0] pick_sym();
    case ($urandom_range(0, 6))
      0: return SA;
      1: return SB;
      2: return SC;
      3: return SD;
      4: return SF;
      5: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) sync();
  endtask

  // Present a beat and hold it until it is accepted. Returns just after the
  // accepting edge, so back-to-back calls stream without a gap.
  task automatic beat(input logic [DW-1:0] d);
    int guard = 0;
    logic acc;
    in_valid = 1;
    in_data  = d;
    do begin
      @(negedge clk);
      acc = in_ready;
      sync();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("beat_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic tbl_write(input int addr, input logic [31:0] data, input bit inv);
    tbl_we = 1; tbl_addr = CODE_W'(addr); tbl_data = data; tbl_inv = inv;
    sync();
    tbl_we = 0; tbl_inv = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] bp_d [3];
    int sent, c0, guard;
    logic acc;

    rst_n = 0; in_valid = 0; in_data = '0; out_ready = 1;
    tbl_we = 0; tbl_addr = '0; tbl_data = '0; tbl_inv = 0; cnt_clr = 0;
    repeat (3) sync();
    rst_n = 1;
    sync();

    // Basic decode with a known result and 2-cycle latency.
    beat(tup(SC, SA, SD, SB));
    @(negedge clk); chk("t1_lat_valid", out_valid, 0);
    @(negedge clk); chk("t1_index", out_index, 142);
    chk("t1_hit", out_hit, 1);
    @(negedge clk); chk("t1_hit_cnt", hit_cnt, 1);
    sync();

    // All 256 default tuples, back-to-back.
    c0 = cyc;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 4; d++)
            beat(tup(dict_sym(a), dict_sym(b), dict_sym(c), dict_sym(d)));
    chk("thru_cycles", cyc - c0, 256);
    idle(4);

    // Misses, then invalidate entry 1.
    beat(tup(SA, 32'h0, SC, SD));
    tbl_write(1, 32'h0, 1);
    beat(tup(SA, SB, SA, SA));
    beat(tup(SA, SA, SA, SA));
    idle(4);

    // Backpressure: out_ready low for 5 cycles while 3 beats are offered.
    bp_d[0] = tup(SA, SA, SA, SD);
    bp_d[1] = tup(SC, SC, SA, SD);
    bp_d[2] = tup(SD, SA, SC, SA);
    out_ready = 0;
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (sent < 3);
      if (sent < 3) in_data = bp_d[sent];
      @(negedge clk);
      acc = in_ready;
      if (c == 2) chk("bp_ready_low", in_ready, 0);
      sync();
      if (acc && in_valid) sent++;
    end
    out_ready = 1;
    guard = 0;
    while (sent < 3 && guard < 20) begin
      in_valid = 1; in_data = bp_d[sent];
      @(negedge clk);
      acc = in_ready;
      sync();
      if (acc) sent++;
      guard++;
    end
    chk("bp_all_sent", sent, 3);
    idle(5);

    // Table write in the same cycle a beat is accepted.
    tbl_we = 1; tbl_addr = 0; tbl_data = SF; tbl_inv = 0;
    beat(tup(SA, SA, SA, SA));
    tbl_we = 0;
    beat(tup(SA, SA, SA, SA));
    beat(tup(SF, SF, SF, SF));
    idle(4);

    // Counter saturation on the 4-bit instance.
    cnt_clr = 1; sync(); cnt_clr = 0;
    for (int k = 0; k < 20; k++) beat(tup(SC, SC, SC, SC));
    idle(4);
    @(negedge clk);
    chk("sat_hit_cnt4", hit_cnt4, 15);
    chk("sat_hit_cnt16", hit_cnt, 20);
    sync();
    // Assert cnt_clr in the same cycle as an output transfer.
    beat(tup(SC, SC, SC, SC));
    sync();
    cnt_clr = 1;
    sync();
    cnt_clr = 0;
    @(negedge clk);
    chk("clr_hit_cnt", hit_cnt, 0);
    chk("clr_hit_cnt4", hit_cnt4, 0);
    sync();

    // Random traffic with random backpressure and table updates.
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = tup(pick_sym(), pick_sym(), pick_sym(), pick_sym());
      tbl_we    = ($urandom_range(0, 15) == 0);
      tbl_addr  = CODE_W'($urandom_range(0, N_CODES - 1));
      tbl_data  = pick_sym();
      tbl_inv   = ($urandom_range(0, 3) == 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
      sync();
    end
    in_valid = 0; tbl_we = 0; tbl_inv = 0; cnt_clr = 0; out_ready = 1;
    idle(5);

    // Reset with two beats in flight.
    tbl_write(3, 32'h0, 1);
    beat(tup(SA, SA, SB, SB));
    beat(tup(SC, SC, SB, SB));
    rst_n = 0;
    repeat (2) sync();
    rst_n = 1;
    idle(4);
    beat(tup(SA, SB, SC, SD));
    @(negedge clk);
    @(negedge clk); chk("post_rst_index", out_index, 28);
    sync();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
